// File: rtl/accum_xcel_mem_resp.sv
// Fixed-latency word memory responder with a side-band preload port; one request in flight,
// response appears p_latency cycles after accept and is held while memresp_rdy is low.
module accum_xcel_mem_resp #(
  parameter int p_nwords  = 64,
  parameter int p_latency = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  input  logic        memreq_type,
  input  logic [31:0] memreq_addr,
  input  logic [31:0] memreq_data,
  output logic        memresp_val,
  input  logic        memresp_rdy,
  output logic        memresp_type,
  output logic [31:0] memresp_data,
  input  logic        init_en,
  input  logic [31:0] init_addr,
  input  logic [31:0] init_data
);

  localparam int AW = $clog2(p_nwords);
  localparam logic [3:0] LAT_M1 = 4'(p_latency - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    cnt;
  logic [31:0]   mem [p_nwords];
  logic [AW-1:0] req_idx;
  logic [AW-1:0] init_idx;
  logic          accept;
  logic          unused_addr_bits;

  assign req_idx  = memreq_addr[AW+1:2];
  assign init_idx = init_addr[AW+1:2];
  assign accept   = memreq_val && memreq_rdy;
  assign unused_addr_bits = ^{memreq_addr[31:AW+2], memreq_addr[1:0],
                              init_addr[31:AW+2], init_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (p_latency == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_next = RESP;
      RESP:    if (memresp_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    memreq_rdy  = (state == IDLE);
    memresp_val = (state == RESP);
  end

  // Read data is snapshotted at accept so later writes cannot disturb a pending response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= 4'd0;
      memresp_type <= 1'b0;
      memresp_data <= 32'd0;
    end else if (accept) begin
      cnt          <= LAT_M1;
      memresp_type <= memreq_type;
      memresp_data <= memreq_type ? 32'd0 : mem[req_idx];
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Request write is placed after the init write so it wins on a same-word collision.
  always_ff @(posedge clk) begin
    if (init_en)               mem[init_idx] <= init_data;
    if (accept && memreq_type) mem[req_idx]  <= memreq_data;
  end

endmodule

// File: tb/tb_accum_xcel_mem_resp.sv
// Directed bench: latency-2 and latency-4 responders, read/write, backpressure, wrap, collisions, reset.
module tb_accum_xcel_mem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          cur;
  logic        q_val, q_type;
  logic [31:0] q_addr, q_data;
  logic        resp_rdy;
  logic        init_en;
  logic [31:0] init_addr, init_data;

  logic        rdy2, val2, typ2;
  logic [31:0] dat2;
  logic        rdy4, val4, typ4;
  logic [31:0] dat4;

  logic        s_rdy, s_val, s_typ;
  logic [31:0] s_dat;

  int tests = 0;
  int fails = 0;

  assign s_rdy = (cur == 0) ? rdy2 : rdy4;
  assign s_val = (cur == 0) ? val2 : val4;
  assign s_typ = (cur == 0) ? typ2 : typ4;
  assign s_dat = (cur == 0) ? dat2 : dat4;

  accum_xcel_mem_resp #(.p_nwords(64), .p_latency(2)) dut2 (
    .clk(clk), .rst(rst),
    .memreq_val(q_val && (cur == 0)), .memreq_rdy(rdy2), .memreq_type(q_type),
    .memreq_addr(q_addr), .memreq_data(q_data),
    .memresp_val(val2), .memresp_rdy(resp_rdy), .memresp_type(typ2), .memresp_data(dat2),
    .init_en(init_en), .init_addr(init_addr), .init_data(init_data)
  );

  accum_xcel_mem_resp #(.p_nwords(64), .p_latency(4)) dut4 (
    .clk(clk), .rst(rst),
    .memreq_val(q_val && (cur == 1)), .memreq_rdy(rdy4), .memreq_type(q_type),
    .memreq_addr(q_addr), .memreq_data(q_data),
    .memresp_val(val4), .memresp_rdy(resp_rdy), .memresp_type(typ4), .memresp_data(dat4),
    .init_en(1'b0), .init_addr(32'd0), .init_data(32'd0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_init(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    init_en = 1'b1; init_addr = a; init_data = d;
    @(negedge clk);
    init_en = 1'b0;
  endtask

  // Returns at the negedge of the first cycle after the accept edge.
  task automatic issue(input logic t, input logic [31:0] a, input logic [31:0] d,
                       input logic ie, input logic [31:0] ia, input logic [31:0] id);
    int n = 0;
    @(negedge clk);
    while (s_rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_rdy", {31'd0, s_rdy}, 32'd1);
    q_val = 1'b1; q_type = t; q_addr = a; q_data = d;
    init_en = ie; init_addr = ia; init_data = id;
    @(negedge clk);
    q_val = 1'b0; init_en = 1'b0;
    chk("req_busy", {31'd0, s_rdy}, 32'd0);
  endtask

  task automatic get_resp(input string tag, input int lat, input logic t, input logic [31:0] d);
    int cyc = 1;
    while (s_val !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_type"}, {31'd0, s_typ}, {31'd0, t});
    chk({tag, "_data"}, s_dat, d);
    if (resp_rdy) begin
      @(negedge clk);
      chk({tag, "_done_val"}, {31'd0, s_val}, 32'd0);
      chk({tag, "_done_rdy"}, {31'd0, s_rdy}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cur = 0; q_val = 1'b0; q_type = 1'b0; q_addr = '0; q_data = '0;
    resp_rdy = 1'b1; init_en = 1'b0; init_addr = '0; init_data = '0;
    #1;
    chk("rst_rdy2", {31'd0, rdy2}, 32'd1);
    chk("rst_val2", {31'd0, val2}, 32'd0);
    chk("rst_typ2", {31'd0, typ2}, 32'd0);
    chk("rst_dat2", dat2, 32'd0);
    chk("rst_rdy4", {31'd0, rdy4}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_init(32'h08, 32'h0000_00AB);
    issue(1'b0, 32'h08, 32'd0, 1'b0, 32'd0, 32'd0);
    get_resp("rd_pre", 2, 1'b0, 32'h0000_00AB);

    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'd0);
    get_resp("wr", 2, 1'b1, 32'd0);
    issue(1'b0, 32'h10, 32'd0, 1'b0, 32'd0, 32'd0);
    get_resp("rd_wr", 2, 1'b0, 32'hDEAD_BEEF);

    do_init(32'h04, 32'h0000_1234);
    resp_rdy = 1'b0;
    issue(1'b0, 32'h04, 32'd0, 1'b0, 32'd0, 32'd0);
    get_resp("bp", 2, 1'b0, 32'h0000_1234);
    for (int i = 0; i < 3; i++) begin
      chk("bp_val", {31'd0, s_val}, 32'd1);
      chk("bp_data", s_dat, 32'h0000_1234);
      chk("bp_rdy", {31'd0, s_rdy}, 32'd0);
      @(negedge clk);
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    chk("bp_consumed_val", {31'd0, s_val}, 32'd0);
    chk("bp_consumed_rdy", {31'd0, s_rdy}, 32'd1);
    @(negedge clk);
    chk("bp_single", {31'd0, s_val}, 32'd0);

    issue(1'b1, 32'h100, 32'h55, 1'b0, 32'd0, 32'd0);
    get_resp("wrap_wr", 2, 1'b1, 32'd0);
    issue(1'b0, 32'h000, 32'd0, 1'b0, 32'd0, 32'd0);
    get_resp("wrap_rd0", 2, 1'b0, 32'h55);
    issue(1'b0, 32'h103, 32'd0, 1'b0, 32'd0, 32'd0);
    get_resp("wrap_rd103", 2, 1'b0, 32'h55);

    issue(1'b1, 32'h20, 32'h2, 1'b1, 32'h20, 32'h1);
    get_resp("coll_wr", 2, 1'b1, 32'd0);
    issue(1'b0, 32'h20, 32'd0, 1'b0, 32'd0, 32'd0);
    get_resp("coll_wr_rd", 2, 1'b0, 32'h2);

    do_init(32'h24, 32'h7);
    issue(1'b0, 32'h24, 32'd0, 1'b1, 32'h24, 32'h9);
    get_resp("coll_rd", 2, 1'b0, 32'h7);
    issue(1'b0, 32'h24, 32'd0, 1'b0, 32'd0, 32'd0);
    get_resp("coll_rd_after", 2, 1'b0, 32'h9);

    cur = 1;
    issue(1'b1, 32'h30, 32'h0000_CAFE, 1'b0, 32'd0, 32'd0);
    get_resp("l4_wr", 4, 1'b1, 32'd0);
    issue(1'b0, 32'h30, 32'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_val", {31'd0, val4}, 32'd0);
    chk("mid_rst_rdy", {31'd0, rdy4}, 32'd1);
    chk("mid_rst_dat", dat4, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_noresp", {31'd0, s_val}, 32'd0);
    end
    chk("post_rst_rdy", {31'd0, s_rdy}, 32'd1);
    issue(1'b0, 32'h30, 32'd0, 1'b0, 32'd0, 32'd0);
    get_resp("l4_rd_kept", 4, 1'b0, 32'h0000_CAFE);

    cur = 0;
    issue(1'b0, 32'h10, 32'd0, 1'b0, 32'd0, 32'd0);
    get_resp("l2_rd_kept", 2, 1'b0, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
